muldiv_unit: RTL and testbench

- Responder side of the EX-stage multi-cycle arithmetic handshake: accepts one mul/div/mod request at a time, computes iteratively, and holds the result until the EX stage acknowledges it.
- Sits inside execution, instantiated by EX. EX drives start/ack/clear and stalls the pipeline while `mul_finished` is low.
- Covers 32-bit low/high products (signed and unsigned) and signed/unsigned quotient and remainder.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv_div_iter.sv | 25 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op-codes, FSM states and op-decode helpers for the mul/div unit.
package muldiv_pkg;

  localparam logic [2:0] MULDIV_MUL   = 3'd0;
  localparam logic [2:0] MULDIV_MULH  = 3'd1;
  localparam logic [2:0] MULDIV_MUL2  = 3'd2;
  localparam logic [2:0] MULDIV_MULHU = 3'd3;
  localparam logic [2:0] MULDIV_DIV   = 3'd4;
  localparam logic [2:0] MULDIV_DIVU  = 3'd5;
  localparam logic [2:0] MULDIV_MOD   = 3'd6;
  localparam logic [2:0] MULDIV_MODU  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  // Ops 0..3 are multiplies, 4..7 divides.
  function automatic logic is_mul(input logic [2:0] op);
    return !op[2];
  endfunction

  // MULH / MULHU return the upper half of the product.
  function automatic logic is_high(input logic [2:0] op);
    return (op == MULDIV_MULH) || (op == MULDIV_MULHU);
  endfunction

  // Only MULH needs a signed product; the low half is sign-agnostic.
  function automatic logic mul_signed(input logic [2:0] op);
    return op == MULDIV_MULH;
  endfunction

  // DIV and MOD are signed; DIVU and MODU are not.
  function automatic logic div_signed(input logic [2:0] op);
    return (op == MULDIV_DIV) || (op == MULDIV_MOD);
  endfunction

  // Remainder ops return the remainder instead of the quotient.
  function automatic logic is_rem(input logic [2:0] op);
    return (op == MULDIV_MOD) || (op == MULDIV_MODU);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor if it fits.
module muldiv_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in DATA_W+1 bits and the top bit of the difference is the borrow.
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {1'b0, divisor};
    q_bit    = !diff[DATA_W];
    rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply / divide responder for the EX stage. Accepts one request
// when idle, computes, and holds the result until acknowledged.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_pipeline,
  input  logic [2:0]        mul_para,
  input  logic              mul_initial,
  input  logic [DATA_W-1:0] mul_rs0,
  input  logic [DATA_W-1:0] mul_rs1,
  output logic              mul_ready,
  output logic              mul_finished,
  output logic [DATA_W-1:0] mul_data,
  input  logic              mul_ack
);

  localparam int CNT_MAX = (DATA_W > MUL_LATENCY) ? DATA_W : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  muldiv_state_t state, next_state;

  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   dvd_q, dvs_q, rem_q;
  logic                neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0]    cnt;

  logic                accept, last_mul, last_div;
  logic [2:0]          cur_op;
  logic [DATA_W-1:0]   mul_a, mul_b, mul_res;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W-1:0]   rem_nx, q_raw, q_fix, r_fix;
  logic                q_bit;

  assign accept   = (state == ST_IDLE) && mul_initial && !clear_pipeline;
  assign last_mul = (cnt == CNT_W'(MUL_LATENCY - 2));
  assign last_div = (cnt == CNT_W'(DATA_W - 1));

  // Multiplier reads live inputs in IDLE (single-cycle latency case) and the
  // captured operands afterwards, so late operand changes are ignored.
  always_comb begin
    cur_op  = (state == ST_IDLE) ? mul_para : op_q;
    mul_a   = (state == ST_IDLE) ? mul_rs0  : a_q;
    mul_b   = (state == ST_IDLE) ? mul_rs1  : b_q;
    ext_a   = mul_signed(cur_op) ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a}
                                 : {{DATA_W{1'b0}}, mul_a};
    ext_b   = mul_signed(cur_op) ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b}
                                 : {{DATA_W{1'b0}}, mul_b};
    prod    = ext_a * ext_b;
    mul_res = is_high(cur_op) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
  end

  // Divider works on magnitudes for signed ops; signs are restored at the end.
  always_comb begin
    a_abs = (div_signed(mul_para) && mul_rs0[DATA_W-1]) ? -mul_rs0 : mul_rs0;
    b_abs = (div_signed(mul_para) && mul_rs1[DATA_W-1]) ? -mul_rs1 : mul_rs1;
    q_raw = {dvd_q[DATA_W-2:0], q_bit};
    q_fix = neg_quo_q ? -q_raw : q_raw;
    r_fix = neg_rem_q ? -rem_nx : rem_nx;
  end

  muldiv_div_iter #(.DATA_W(DATA_W)) u_div_iter (
    .rem      (rem_q),
    .bit_in   (dvd_q[DATA_W-1]),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; clear_pipeline overrides everything.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (mul_initial) begin
        if (is_mul(mul_para))  next_state = (MUL_LATENCY == 1) ? ST_DONE : ST_MUL;
        else if (mul_rs1 == '0) next_state = ST_DONE;
        else                    next_state = ST_DIV;
      end
      ST_MUL:  if (last_mul) next_state = ST_DONE;
      ST_DIV:  if (last_div) next_state = ST_DONE;
      ST_DONE: if (mul_ack)  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    if (clear_pipeline) next_state = ST_IDLE;
  end

  // Handshake outputs decoded from state.
  always_comb begin
    mul_ready    = (state == ST_IDLE);
    mul_finished = (state == ST_DONE);
  end

  // Operand capture, iteration registers and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt       <= '0;
      mul_data  <= '0;
    end else begin
      if (accept) begin
        op_q      <= mul_para;
        a_q       <= mul_rs0;
        b_q       <= mul_rs1;
        dvd_q     <= a_abs;
        dvs_q     <= b_abs;
        rem_q     <= '0;
        cnt       <= '0;
        neg_quo_q <= div_signed(mul_para) && (mul_rs0[DATA_W-1] ^ mul_rs1[DATA_W-1]);
        neg_rem_q <= div_signed(mul_para) && mul_rs0[DATA_W-1];
      end else if (state == ST_MUL || state == ST_DIV) begin
        cnt <= cnt + CNT_W'(1);
        if (state == ST_DIV) begin
          rem_q <= rem_nx;
          dvd_q <= q_raw;  // quotient bits shift in behind the dividend
        end
      end
      if (next_state == ST_DONE && state != ST_DONE) begin
        case (state)
          ST_IDLE: mul_data <= is_mul(mul_para) ? mul_res
                             : (is_rem(mul_para) ? mul_rs0 : '1);
          ST_MUL:  mul_data <= mul_res;
          ST_DIV:  mul_data <= is_rem(op_q) ? r_fix : q_fix;
          default: mul_data <= mul_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected results from an
// arithmetic reference model, monitor pops on each rising mul_finished.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst, clear_pipeline, mul_initial, mul_ack;
  logic [2:0]   mul_para;
  logic [W-1:0] mul_rs0, mul_rs1, mul_data;
  logic         mul_ready, mul_finished;

  muldiv_unit #(.DATA_W(W), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .clear_pipeline(clear_pipeline),
    .mul_para(mul_para), .mul_initial(mul_initial),
    .mul_rs0(mul_rs0), .mul_rs1(mul_rs1),
    .mul_ready(mul_ready), .mul_finished(mul_finished),
    .mul_data(mul_data), .mul_ack(mul_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           t;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model built on plain 64-bit SV arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0, 3'd2: begin p = sa * sb; return p[31:0]; end
      3'd1:       begin p = sa * sb; return p[63:32]; end
      3'd3:       begin p = ua * ub; return p[63:32]; end
      3'd4:       begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5:       begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6:       begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default:    begin if (b == 0) return a;  p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] b);
    if (op <= 3'd3) return LAT;
    if (b == 0)     return 1;
    return W + 1;
  endfunction

  // Monitor: compare on every rising edge of mul_finished.
  logic fin_q = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && mul_finished && !fin_q) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_finished: got finished=1 expected no result (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("data", mul_data, e.data);
        chk("latency", cyc - e.t, e.lat);
      end
    end
    fin_q = mul_finished;
  end

  // Issue one op, optionally hold off ack for some cycles, then acknowledge.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int           n;
    logic [W-1:0] ev;
    exp_t         e;
    n = 0;
    while (!mul_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_before_start", mul_ready, 1);
    ev = model(op, a, b);
    mul_para = op; mul_rs0 = a; mul_rs1 = b; mul_initial = 1'b1;
    e.data = ev; e.lat = lat_of(op, b); e.t = cyc;
    sbq.push_back(e);
    @(posedge clk); #1;
    mul_initial = 1'b0;
    mul_rs0 = $urandom; mul_rs1 = $urandom; mul_para = 3'($urandom_range(0, 7));
    n = 0;
    while (!mul_finished && n < 100) begin @(negedge clk); n++; end
    chk("finish_timeout", mul_finished, 1);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", mul_data, ev);
      chk("hold_finished", mul_finished, 1);
      chk("hold_not_ready", mul_ready, 0);
    end
    @(posedge clk); #1; mul_ack = 1'b1;
    @(posedge clk); #1; mul_ack = 1'b0;
    chk("ready_after_ack", mul_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int           t;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    rst = 1'b1; clear_pipeline = 1'b0; mul_initial = 1'b0; mul_ack = 1'b0;
    mul_para = '0; mul_rs0 = '0; mul_rs1 = '0;
    #12;
    chk("reset_ready", mul_ready, 1);
    chk("reset_finished", mul_finished, 0);
    chk("reset_data", mul_data, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed multiplies, divides and boundary cases.
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 2);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd5, 32'h1234, 32'd0, 3);
    run_op(3'd7, 32'h1234, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'd7, 32'd0, 0);
    run_op(3'd6, 32'hFFFF_FFF0, 32'd0, 0);

    // Random ops with biased divisors.
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      run_op(op, a, b, int'($urandom_range(0, 2)));
    end

    // Abort a divide at T+10 while also raising mul_initial.
    @(posedge clk); #1;
    mul_para = 3'd4; mul_rs0 = 32'd1000; mul_rs1 = 32'd3; mul_initial = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    mul_initial = 1'b0;
    chk("abort_busy", mul_ready, 0);
    while (cyc < t + 10) begin @(posedge clk); #1; end
    clear_pipeline = 1'b1; mul_initial = 1'b1; mul_para = 3'd0;
    @(posedge clk); #1;
    clear_pipeline = 1'b0; mul_initial = 1'b0;
    chk("abort_ready", mul_ready, 1);
    chk("abort_finished", mul_finished, 0);
    repeat (40) begin
      @(negedge clk);
      chk("abort_no_finish", mul_finished, 0);
      chk("abort_stay_idle", mul_ready, 1);
    end

    // Leave a nonzero result, then reset asynchronously mid-multiply.
    run_op(3'd5, 32'd100, 32'd7, 0);
    @(posedge clk); #1;
    mul_para = 3'd0; mul_rs0 = 32'd5; mul_rs1 = 32'd6; mul_initial = 1'b1;
    @(posedge clk); #1;
    mul_initial = 1'b0;
    chk("mul_busy", mul_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ready", mul_ready, 1);
    chk("async_rst_finished", mul_finished, 0);
    chk("async_rst_data", mul_data, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
